des_result_writer: RTL and testbench

DES_RESULT_WRITER -- requirements
Module: des_result_writer

---
 rtl/des_result_writer.sv | 138 +++++++++++++
 tb/tb_des_result_writer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_result_writer.sv
// des_result_writer: buffers DES ciphertext blocks in a small FIFO and writes
// them to consecutive memory words until one full image has been stored.
module des_result_writer #(
  parameter int ROWS       = 133,
  parameter int COLS       = 200,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_din,
  input  logic              des_valid_din,
  input  logic [63:0]       des_data_din,
  output logic              des_ready_dout,
  output logic              mem_wr_en_dout,
  output logic [ADDR_W-1:0] mem_addr_dout,
  output logic [63:0]       mem_data_dout,
  input  logic              mem_ack_din,
  output logic              busy_dout,
  output logic              done_dout,
  output logic              overflow_dout
);

  localparam int TOTAL = (ROWS * COLS) / 8;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [PTR_W:0]    FULL_OCC  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  in_count_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    occ_reg;
  logic              done_reg, overflow_reg;
  logic [63:0]       fifo_mem [FIFO_DEPTH];

  logic fifo_full, fifo_empty;
  logic push, pop, arm, finish, overflow_set;

  assign fifo_full    = (occ_reg == FULL_OCC);
  assign fifo_empty   = (occ_reg == '0);
  assign push         = des_valid_din && des_ready_dout;
  assign pop          = mem_wr_en_dout && mem_ack_din;
  // Any block offered outside RUN is dropped and flagged.
  assign overflow_set = des_valid_din && (state_reg != RUN);

  assign mem_addr_dout = wr_addr_reg;
  // Data is forced to zero when no write is pending so that reset (and idle)
  // presents all-zero outputs even though FIFO storage is not cleared.
  assign mem_data_dout = mem_wr_en_dout ? fifo_mem[rd_ptr_reg] : '0;
  assign done_dout     = done_reg;
  assign overflow_dout = overflow_reg;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next     = state_reg;
    des_ready_dout = 1'b0;
    mem_wr_en_dout = 1'b0;
    busy_dout      = 1'b0;
    arm            = 1'b0;
    finish         = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start_din) begin
          state_next = RUN;
          arm        = 1'b1;
        end
      end
      RUN: begin
        busy_dout      = 1'b1;
        des_ready_dout = !fifo_full && (in_count_reg < LAST_CNT + 1'b1);
        mem_wr_en_dout = !fifo_empty;
        if (des_valid_din && !fifo_full && in_count_reg == LAST_CNT)
          state_next = DRAIN;
      end
      DRAIN: begin
        busy_dout      = 1'b1;
        mem_wr_en_dout = !fifo_empty;
        if (!fifo_empty && mem_ack_din && wr_addr_reg == LAST_ADDR) begin
          state_next = DONE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, FIFO pointers and sticky status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_count_reg <= '0;
      wr_addr_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (arm) begin
      in_count_reg <= '0;
      wr_addr_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg   <= wr_ptr_reg + 1'b1;
        in_count_reg <= in_count_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        // The address saturates at the last word of the image.
        if (wr_addr_reg != LAST_ADDR) wr_addr_reg <= wr_addr_reg + 1'b1;
      end
      if (push && !pop)      occ_reg <= occ_reg + 1'b1;
      else if (pop && !push) occ_reg <= occ_reg - 1'b1;
      if (overflow_set) overflow_reg <= 1'b1;
      if (finish)       done_reg     <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= des_data_din;
  end

endmodule

// File: tb/tb_des_result_writer.sv
// tb_des_result_writer: randomized bench for des_result_writer with a
// transaction-level reference model (counts of accepted and written blocks).
module tb_des_result_writer;

  localparam int DEPTH       = 4;
  localparam int TOTAL_BIG   = 3325;
  localparam int TOTAL_SMALL = 2;
  localparam int BOUND       = 20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s [2];
  logic        valid_s [2];
  logic [63:0] data_s  [2];
  logic        ack_s   [2];
  logic        rdy_s   [2];
  logic        wen_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        ovf_s   [2];
  logic [63:0] mdata_s [2];
  logic [11:0] addr_big;
  logic [0:0]  addr_small;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: image armed?, blocks accepted, blocks written, overflow.
  bit          armed_m [2];
  int          acc_m   [2];
  int          wr_m    [2];
  bit          ovf_m   [2];
  logic [63:0] blk_m   [2][4096];

  always #5 clk = ~clk;

  des_result_writer #(.ROWS(133), .COLS(200), .FIFO_DEPTH(DEPTH), .ADDR_W(12)) dut_big (
    .clk(clk), .reset(rst_n), .start_din(start_s[0]), .des_valid_din(valid_s[0]),
    .des_data_din(data_s[0]), .des_ready_dout(rdy_s[0]), .mem_wr_en_dout(wen_s[0]),
    .mem_addr_dout(addr_big), .mem_data_dout(mdata_s[0]), .mem_ack_din(ack_s[0]),
    .busy_dout(busy_s[0]), .done_dout(done_s[0]), .overflow_dout(ovf_s[0])
  );

  des_result_writer #(.ROWS(2), .COLS(8), .FIFO_DEPTH(DEPTH), .ADDR_W(1)) dut_small (
    .clk(clk), .reset(rst_n), .start_din(start_s[1]), .des_valid_din(valid_s[1]),
    .des_data_din(data_s[1]), .des_ready_dout(rdy_s[1]), .mem_wr_en_dout(wen_s[1]),
    .mem_addr_dout(addr_small), .mem_data_dout(mdata_s[1]), .mem_ack_din(ack_s[1]),
    .busy_dout(busy_s[1]), .done_dout(done_s[1]), .overflow_dout(ovf_s[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic string pfx(input int k);
    return (k == 0) ? "big" : "small";
  endfunction

  function automatic int total_of(input int k);
    return (k == 0) ? TOTAL_BIG : TOTAL_SMALL;
  endfunction

  function automatic logic [63:0] addr_of(input int k);
    return (k == 0) ? 64'(addr_big) : 64'(addr_small);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int k, input string tag);
    check({pfx(k), "_", tag, "_rdy"},   rdy_s[k],   0);
    check({pfx(k), "_", tag, "_wen"},   wen_s[k],   0);
    check({pfx(k), "_", tag, "_busy"},  busy_s[k],  0);
    check({pfx(k), "_", tag, "_done"},  done_s[k],  0);
    check({pfx(k), "_", tag, "_ovf"},   ovf_s[k],   0);
    check({pfx(k), "_", tag, "_addr"},  addr_of(k), 0);
    check({pfx(k), "_", tag, "_mdata"}, mdata_s[k], 0);
  endtask

  // Compare DUT outputs with the model, then advance the model across the
  // coming clock edge using the inputs that will be sampled there.
  task automatic model_step(input int k);
    int  tot;
    bit  run_e, rdy_e, wen_e, busy_e, done_e;
    tot = total_of(k);
    if (rst_n !== 1'b1) begin
      check_zero(k, "rst");
      armed_m[k] = 0; acc_m[k] = 0; wr_m[k] = 0; ovf_m[k] = 0;
      return;
    end
    run_e  = armed_m[k] && (acc_m[k] < tot);
    rdy_e  = run_e && (acc_m[k] - wr_m[k] < DEPTH);
    wen_e  = armed_m[k] && (wr_m[k] < acc_m[k]);
    busy_e = armed_m[k] && (wr_m[k] < tot);
    done_e = armed_m[k] && (wr_m[k] == tot);
    check({pfx(k), "_ready"}, rdy_s[k], rdy_e);
    check({pfx(k), "_wr_en"}, wen_s[k], wen_e);
    check({pfx(k), "_busy"},  busy_s[k], busy_e);
    check({pfx(k), "_done"},  done_s[k], done_e);
    check({pfx(k), "_ovf"},   ovf_s[k],  ovf_m[k]);
    if (wen_e) begin
      check({pfx(k), "_addr"}, addr_of(k), 64'(wr_m[k]));
      check({pfx(k), "_data"}, mdata_s[k], blk_m[k][wr_m[k]]);
    end
    if (!armed_m[k]) check({pfx(k), "_idle_addr"}, addr_of(k), 0);
    if (start_s[k] && !busy_e) begin
      armed_m[k] = 1; acc_m[k] = 0; wr_m[k] = 0; ovf_m[k] = 0;
    end else begin
      if (valid_s[k] && !run_e) ovf_m[k] = 1;
      if (wen_e && ack_s[k]) wr_m[k]++;
      if (valid_s[k] && rdy_e) begin
        blk_m[k][acc_m[k]] = data_s[k];
        acc_m[k]++;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic pulse_start(input int k);
    start_s[k] = 1'b1;
    valid_s[k] = 1'b0;
    tick();
    start_s[k] = 1'b0;
  endtask

  // Offer nblk blocks (valid with probability vp%, ack with ap%); when
  // stall_at blocks have gone in, hold ack low for 20 cycles with valid high.
  task automatic run_stream(input int k, input int nblk, input int vp, input int ap,
                            input int stall_at, output int cyc);
    int sent;
    bit hs;
    int stall;
    sent = 0; cyc = 0; stall = stall_at;
    while (sent < nblk && cyc < BOUND) begin
      if (sent == stall) begin
        int base, got;
        logic [63:0] a0, d0;
        base = acc_m[k] - wr_m[k];
        got = 0; a0 = '0; d0 = '0;
        ack_s[k] = 1'b0;
        valid_s[k] = 1'b1;
        for (int i = 0; i < 20; i++) begin
          data_s[k] = {$urandom, $urandom};
          hs = rdy_s[k];
          tick(); cyc++;
          if (hs) begin got++; sent++; end
          if (i == 0) begin a0 = addr_of(k); d0 = mdata_s[k]; end
        end
        check({pfx(k), "_stall_accepted"}, got, DEPTH - base);
        check({pfx(k), "_stall_ready"}, rdy_s[k], 0);
        check({pfx(k), "_stall_wen"}, wen_s[k], 1);
        check({pfx(k), "_stall_addr"}, addr_of(k), a0);
        check({pfx(k), "_stall_data"}, mdata_s[k], d0);
        stall = -1;
      end else begin
        valid_s[k] = ($urandom_range(0, 99) < vp);
        data_s[k]  = {$urandom, $urandom};
        ack_s[k]   = ($urandom_range(0, 99) < ap);
        hs = valid_s[k] && rdy_s[k];
        tick(); cyc++;
        if (hs) sent++;
      end
    end
    valid_s[k] = 1'b0;
    if (sent < nblk) check({pfx(k), "_stream_timeout"}, sent, nblk);
  endtask

  task automatic wait_done(input int k, input int ap, output int w);
    w = 0;
    valid_s[k] = 1'b0;
    while (done_s[k] !== 1'b1 && w < BOUND) begin
      ack_s[k] = ($urandom_range(0, 99) < ap);
      tick(); w++;
    end
    check({pfx(k), "_done_reached"}, done_s[k], 1);
    ack_s[k] = 1'b0;
  endtask

  initial begin
    int cyc, w, n;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 0; valid_s[k] = 0; data_s[k] = '0; ack_s[k] = 0;
      armed_m[k] = 0; acc_m[k] = 0; wr_m[k] = 0; ovf_m[k] = 0;
    end
    repeat (3) tick();
    check_zero(0, "por");
    check_zero(1, "por");
    rst_n = 1'b1;
    $display("reset: outputs zero after power-on reset");

    // Idle: acks alone must not cause writes.
    repeat (5) begin ack_s[0] = 1'($urandom); tick(); end
    ack_s[0] = 1'b0;
    $display("idle: no write before start");

    // Block offered before start flags overflow; start clears it.
    valid_s[0] = 1'b1; data_s[0] = {$urandom, $urandom};
    tick(); tick();
    valid_s[0] = 1'b0;
    check("big_pre_ovf", ovf_s[0], 1);
    check("big_pre_ready", rdy_s[0], 0);
    check("big_pre_wen", wen_s[0], 0);
    pulse_start(0);
    check("big_start_clears_ovf", ovf_s[0], 0);
    $display("overflow: early block flagged, cleared by start");

    // Full image at one block per cycle.
    run_stream(0, TOTAL_BIG, 100, 100, -1, cyc);
    wait_done(0, 100, w);
    check("big_full_rate_cycles", cyc + w, TOTAL_BIG + 1);
    check("big_busy_after_done", busy_s[0], 0);
    $display("full image: %0d blocks in %0d cycles", TOTAL_BIG, cyc + w);

    // Re-arm from DONE; random traffic with an ack stall mid-stream.
    pulse_start(0);
    check("big_rearm_done_clear", done_s[0], 0);
    run_stream(0, TOTAL_BIG, 80, 75, 500, cyc);
    wait_done(0, 60, w);
    $display("random image with stall: done after %0d cycles", cyc + w);

    // Reset in the middle of a capture.
    pulse_start(0);
    run_stream(0, 100, 90, 60, -1, cyc);
    rst_n = 1'b0;
    #1;
    check_zero(0, "midrst");
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start(0);
    valid_s[0] = 1'b1; data_s[0] = {$urandom, $urandom}; ack_s[0] = 1'b0;
    n = 0;
    while (wen_s[0] !== 1'b1 && n < 10) begin tick(); n++; end
    valid_s[0] = 1'b0;
    check("big_after_rst_wen", wen_s[0], 1);
    check("big_after_rst_addr", addr_big, 0);
    $display("mid-capture reset: first write after restart at address 0");

    // Tiny image: start during DRAIN ignored, then a second full run.
    pulse_start(1);
    run_stream(1, TOTAL_SMALL, 100, 0, -1, cyc);
    pulse_start(1);
    check("small_drain_busy", busy_s[1], 1);
    check("small_drain_done", done_s[1], 0);
    wait_done(1, 100, w);
    check("small_done_addr", addr_small, 1);
    pulse_start(1);
    check("small_rerun_done_clear", done_s[1], 0);
    run_stream(1, TOTAL_SMALL, 70, 70, -1, cyc);
    wait_done(1, 70, w);
    $display("tiny image: start in drain ignored, re-run completed");

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
